fetch_sequencer: RTL and testbench

Controls the instruction-fetch stage and the rest of the MIPS pipeline during debug.
- Takes a byte stream from the UART receiver and assembles it into 32-bit instruction words.
- Writes those words into the instruction RAM through its write port.
- Holds the PC in reset while loading.
- Releases the pipeline either in continuous mode or one clock per step command.
- Freezes the pipeline when the HALT instruction retires.

---
 rtl/fetch_sequencer_pkg.sv | 23 ++
 rtl/fetch_sequencer_word_assembler.sv | 38 +++
 rtl/fetch_sequencer.sv | 124 ++++++++++++
 tb/tb_fetch_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared state encodings and command bytes for the debug fetch sequencer.
// Also used by the UART TX reporter that decodes out_state.
package fetch_sequencer_pkg;

    localparam int          WORD_LEN    = 32;
    localparam int          RAM_AW      = 11;
    localparam logic [31:0] MARKER_WORD = 32'hFFFF_FFFF;

    localparam logic [7:0] CHAR_CONT   = 8'h63;
    localparam logic [7:0] CHAR_STEP   = 8'h73;
    localparam logic [7:0] CHAR_NEXT   = 8'h6E;
    localparam logic [7:0] CHAR_RELOAD = 8'h72;

    typedef enum logic [2:0] {
        ST_LOAD      = 3'd0,
        ST_WAIT_MODE = 3'd1,
        ST_RUN_CONT  = 3'd2,
        ST_STEP_WAIT = 3'd3,
        ST_STEP_EXEC = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

endpackage

// File: rtl/fetch_sequencer_word_assembler.sv
// Packs received bytes MSB-first into a word and flags the final byte.
// word is combinational so the caller can act in the same cycle.
module word_assembler #(
    parameter int len = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           enable,
    input  logic [7:0]     rx_data,
    input  logic           rx_done,
    output logic [len-1:0] word,
    output logic           word_valid
);

    localparam int BYTES = len / 8;
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

    logic [len-1:0] shift;
    logic [CW-1:0]  count;
    logic           take;

    assign take       = enable && rx_done;
    assign word       = {shift[len-9:0], rx_data};
    assign word_valid = take && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shift <= '0;
            count <= '0;
        end else if (take) begin
            shift <= word;
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Debug controller: loads instruction RAM from UART bytes, then runs
// the pipeline continuously or one step per command until HALT.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int          len         = WORD_LEN,
    parameter int          ADDR_WIDTH  = RAM_AW,
    parameter logic [31:0] END_MARKER  = MARKER_WORD,
    parameter logic [7:0]  CMD_CONT    = CHAR_CONT,
    parameter logic [7:0]  CMD_STEP    = CHAR_STEP,
    parameter logic [7:0]  CMD_NEXT    = CHAR_NEXT,
    parameter logic [7:0]  CMD_RELOAD  = CHAR_RELOAD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_rx_data,
    input  logic                  in_rx_done,
    input  logic                  in_halt,
    output logic                  out_wr_en,
    output logic [ADDR_WIDTH-1:0] out_wr_addr,
    output logic [len-1:0]        out_wr_data,
    output logic                  out_pc_reset,
    output logic                  out_pipe_enable,
    output logic                  out_step_done,
    output logic                  out_done,
    output logic [2:0]            out_state
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [len-1:0]        word;
    logic                  word_valid;
    logic                  is_marker;
    logic                  write_word;
    logic                  reload;

    word_assembler #(.len(len)) u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (reload),
        .enable     (state == ST_LOAD),
        .rx_data    (in_rx_data),
        .rx_done    (in_rx_done),
        .word       (word),
        .word_valid (word_valid)
    );

    assign is_marker  = (word == len'(END_MARKER));
    assign write_word = (state == ST_LOAD) && word_valid && !is_marker;
    assign reload     = (state == ST_DONE) && in_rx_done
                        && (in_rx_data == CMD_RELOAD);
    assign out_state  = state;

    always_comb begin
        state_next = state;
        unique case (state)
            ST_LOAD: begin
                if (word_valid && (is_marker || addr == ADDR_MAX))
                    state_next = ST_WAIT_MODE;
            end
            ST_WAIT_MODE: begin
                unique case (1'b1)
                    (in_rx_done && in_rx_data == CMD_CONT):
                        state_next = ST_RUN_CONT;
                    (in_rx_done && in_rx_data == CMD_STEP):
                        state_next = ST_STEP_WAIT;
                    default: ;
                endcase
            end
            ST_RUN_CONT: begin
                if (in_halt)
                    state_next = ST_DONE;
            end
            ST_STEP_WAIT: begin
                if (in_rx_done && in_rx_data == CMD_NEXT)
                    state_next = ST_STEP_EXEC;
            end
            ST_STEP_EXEC: begin
                state_next = in_halt ? ST_DONE : ST_STEP_WAIT;
            end
            ST_DONE: begin
                if (reload)
                    state_next = ST_LOAD;
            end
            default: state_next = ST_LOAD;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_LOAD;
            addr            <= '0;
            out_wr_en       <= 1'b0;
            out_wr_addr     <= '0;
            out_wr_data     <= '0;
            out_pc_reset    <= 1'b1;
            out_pipe_enable <= 1'b0;
            out_step_done   <= 1'b0;
            out_done        <= 1'b0;
        end else begin
            state     <= state_next;
            out_wr_en <= write_word;
            if (write_word) begin
                out_wr_addr <= addr;
                out_wr_data <= word;
                if (addr != ADDR_MAX)
                    addr <= addr + 1'b1;
            end
            if (reload)
                addr <= '0;
            out_pc_reset    <= (state_next == ST_LOAD)
                               || (state_next == ST_WAIT_MODE);
            out_pipe_enable <= (state_next == ST_RUN_CONT)
                               || (state_next == ST_STEP_EXEC);
            out_step_done   <= (state == ST_STEP_EXEC);
            out_done        <= (state_next == ST_DONE);
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: load, continuous run, stepping,
// reload, reset mid-word and RAM-full behaviour.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic        clk;
    logic        reset;
    logic [7:0]  in_rx_data;
    logic        in_rx_done;
    logic        in_halt;
    logic        out_wr_en;
    logic [10:0] out_wr_addr;
    logic [31:0] out_wr_data;
    logic        out_pc_reset;
    logic        out_pipe_enable;
    logic        out_step_done;
    logic        out_done;
    logic [2:0]  out_state;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int pe_cnt = 0;
    int sd_cnt = 0;
    logic [10:0] last_addr = '0;
    logic [31:0] last_data = '0;

    fetch_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .in_rx_data      (in_rx_data),
        .in_rx_done      (in_rx_done),
        .in_halt         (in_halt),
        .out_wr_en       (out_wr_en),
        .out_wr_addr     (out_wr_addr),
        .out_wr_data     (out_wr_data),
        .out_pc_reset    (out_pc_reset),
        .out_pipe_enable (out_pipe_enable),
        .out_step_done   (out_step_done),
        .out_done        (out_done),
        .out_state       (out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_wr_en) begin
            wr_cnt    = wr_cnt + 1;
            last_addr = out_wr_addr;
            last_data = out_wr_data;
        end
        if (out_pipe_enable) pe_cnt = pe_cnt + 1;
        if (out_step_done) sd_cnt = sd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_rx_data = b;
        in_rx_done = 1'b1;
        tick();
        in_rx_done = 1'b0;
        tick();
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int pe0, sd0, w0;

    initial begin
        reset      = 1'b1;
        in_rx_data = 8'h00;
        in_rx_done = 1'b0;
        in_halt    = 1'b0;
        repeat (3) tick();
        check("rst_state", 32'(out_state), 32'd0);
        check("rst_pc_reset", 32'(out_pc_reset), 32'd1);
        check("rst_pipe_en", 32'(out_pipe_enable), 32'd0);
        check("rst_wr_en", 32'(out_wr_en), 32'd0);
        check("rst_done", 32'(out_done), 32'd0);
        check("rst_step_done", 32'(out_step_done), 32'd0);
        reset = 1'b0;
        tick();

        // Load two words then the end marker
        send_word(32'h2001_0005);
        check("t1_cnt0", 32'(wr_cnt), 32'd1);
        check("t1_addr0", 32'(last_addr), 32'd0);
        check("t1_data0", last_data, 32'h2001_0005);
        send_word(32'h0000_0000);
        check("t1_cnt1", 32'(wr_cnt), 32'd2);
        check("t1_addr1", 32'(last_addr), 32'd1);
        check("t1_data1", last_data, 32'h0000_0000);
        send_word(32'hFFFF_FFFF);
        check("t1_marker_nowr", 32'(wr_cnt), 32'd2);
        check("t1_state", 32'(out_state), 32'd1);
        check("t1_pc_reset", 32'(out_pc_reset), 32'd1);

        in_halt = 1'b1;
        repeat (2) tick();
        check("halt_ign_wait", 32'(out_state), 32'd1);
        in_halt = 1'b0;

        // Continuous run, halt ten cycles after the command
        pe0 = pe_cnt;
        send_byte(8'h63);
        check("t2_pc_reset", 32'(out_pc_reset), 32'd0);
        check("t2_state_run", 32'(out_state), 32'd2);
        repeat (8) @(posedge clk);
        #1;
        in_halt = 1'b1;
        tick();
        in_halt = 1'b0;
        repeat (2) tick();
        check("t2_pe_cycles", 32'(pe_cnt - pe0), 32'd10);
        check("t2_done", 32'(out_done), 32'd1);
        check("t2_state", 32'(out_state), 32'd5);
        check("t2_pipe_off", 32'(out_pipe_enable), 32'd0);

        // In DONE: 'c' ignored, 'r' reloads from address 0
        send_byte(8'h63);
        check("t6_ign_state", 32'(out_state), 32'd5);
        check("t6_ign_done", 32'(out_done), 32'd1);
        send_byte(8'h72);
        check("t6_state", 32'(out_state), 32'd0);
        check("t6_done", 32'(out_done), 32'd0);
        check("t6_pc_reset", 32'(out_pc_reset), 32'd1);
        send_word(32'hCAFE_F00D);
        check("t6_cnt", 32'(wr_cnt), 32'd3);
        check("t6_addr", 32'(last_addr), 32'd0);
        check("t6_data", last_data, 32'hCAFE_F00D);
        send_word(32'hFFFF_FFFF);
        check("t6_wait", 32'(out_state), 32'd1);

        // Step mode
        send_byte(8'h73);
        check("t3_state", 32'(out_state), 32'd3);
        check("t3_pc_reset", 32'(out_pc_reset), 32'd0);
        pe0 = pe_cnt;
        sd0 = sd_cnt;
        send_byte(8'h41);
        tick();
        check("t3_ign_pe", 32'(pe_cnt - pe0), 32'd0);
        check("t3_ign_sd", 32'(sd_cnt - sd0), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            send_byte(8'h6E);
            tick();
            check("t3_pe", 32'(pe_cnt - pe0), 32'(i));
            check("t3_sd", 32'(sd_cnt - sd0), 32'(i));
            check("t3_back_wait", 32'(out_state), 32'd3);
        end
        in_halt = 1'b1;
        repeat (2) tick();
        check("halt_ign_stepwait", 32'(out_state), 32'd3);
        send_byte(8'h6E);
        tick();
        in_halt = 1'b0;
        check("t3_halt_state", 32'(out_state), 32'd5);
        check("t3_halt_sd", 32'(sd_cnt - sd0), 32'd4);
        check("t3_halt_pe", 32'(pe_cnt - pe0), 32'd4);
        check("t3_halt_done", 32'(out_done), 32'd1);

        // Reset in the middle of a word
        pulse_reset();
        send_byte(8'hAB);
        send_byte(8'hCD);
        pulse_reset();
        check("t5_rst_state", 32'(out_state), 32'd0);
        check("t5_rst_done", 32'(out_done), 32'd0);
        w0 = wr_cnt;
        send_word(32'h1234_5678);
        check("t5_cnt", 32'(wr_cnt - w0), 32'd1);
        check("t5_addr", 32'(last_addr), 32'd0);
        check("t5_data", last_data, 32'h1234_5678);

        // Fill the rest of the RAM
        for (int i = 1; i < 2048; i++) begin
            send_word(32'h0100_0000 | 32'(i));
        end
        check("t4_cnt", 32'(wr_cnt - w0), 32'd2048);
        check("t4_addr", 32'(last_addr), 32'd2047);
        check("t4_data", last_data, 32'h0100_07FF);
        check("t4_state", 32'(out_state), 32'd1);
        send_word(32'hAABB_CCDD);
        check("t4_no_extra", 32'(wr_cnt - w0), 32'd2048);
        check("t4_state_hold", 32'(out_state), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
